// File: rtl/fifo_key_ctrl.sv
// fifo_key_ctrl
// Front end between two raw active-low push-buttons and a FIFO. Each key is
// synchronised and edge-detected into a one-cycle event. Events are parked in
// 1-deep pending flags, then served by a small FSM. The FSM issues single-cycle
// wr_en/rd_en strobes, or flags a sticky error when the FIFO cannot accept the
// operation. Every strobe or reject is followed by a hold-off window.
module fifo_key_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int HOLDOFF    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  key_wr_n,
  input  logic                  key_rd_n,
  input  logic [DATA_WIDTH-1:0] din_sw,
  input  logic                  full,
  input  logic                  empty,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_en,
  output logic                  err_full,
  output logic                  err_empty,
  output logic                  busy
);

  // Hold-off counter must be able to hold the value HOLDOFF itself.
  localparam int                CNT_W    = $clog2(HOLDOFF + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLDOFF);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Key synchronisers and edge-detect history.
  logic r_wr_sync1, r_wr_sync2, r_wr_prev;
  logic r_rd_sync1, r_rd_sync2, r_rd_prev;
  logic w_wr_evt, w_rd_evt;

  // Pending requests and captured write data.
  logic                  r_pend_wr, r_pend_rd;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  w_wr_consume, w_rd_consume;

  // FSM state and registered outputs.
  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_wr_en, w_wr_en_nxt;
  logic                  r_rd_en, w_rd_en_nxt;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_nxt;
  logic                  r_err_full, w_err_full_nxt;
  logic                  r_err_empty, w_err_empty_nxt;
  logic                  r_busy, w_busy_nxt;

  // Two-flop synchronisers plus previous-value regs.
  // Reset loads the "pressed" value, so a key held through reset stays silent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_sync1 <= 1'b1;
      r_wr_sync2 <= 1'b1;
      r_wr_prev  <= 1'b1;
      r_rd_sync1 <= 1'b1;
      r_rd_sync2 <= 1'b1;
      r_rd_prev  <= 1'b1;
    end else begin
      r_wr_sync1 <= ~key_wr_n;
      r_wr_sync2 <= r_wr_sync1;
      r_wr_prev  <= r_wr_sync2;
      r_rd_sync1 <= ~key_rd_n;
      r_rd_sync2 <= r_rd_sync1;
      r_rd_prev  <= r_rd_sync2;
    end
  end

  // One event per press: the rising edge of the synchronised key level.
  assign w_wr_evt = r_wr_sync2 & ~r_wr_prev;
  assign w_rd_evt = r_rd_sync2 & ~r_rd_prev;

  // Pending flags are 1-deep.
  // An event arriving while a request is still waiting is dropped.
  // An event in the cycle that request is consumed re-arms the flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_wr   <= 1'b0;
      r_pend_rd   <= 1'b0;
      r_hold_data <= {DATA_WIDTH{1'b0}};
    end else begin
      r_pend_wr <= (r_pend_wr & ~w_wr_consume) | w_wr_evt;
      r_pend_rd <= (r_pend_rd & ~w_rd_consume) | w_rd_evt;
      if (w_wr_evt && (!r_pend_wr || w_wr_consume)) begin
        r_hold_data <= din_sw;
      end else begin
        r_hold_data <= r_hold_data;
      end
    end
  end

  // Next-state and next-output logic.
  // Write has priority over read, and full/empty only matter in IDLE.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_wr_en_nxt     = 1'b0;
    w_rd_en_nxt     = 1'b0;
    w_wr_data_nxt   = r_wr_data;
    w_err_full_nxt  = r_err_full;
    w_err_empty_nxt = r_err_empty;
    w_wr_consume    = 1'b0;
    w_rd_consume    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_wr) begin
          w_wr_consume = 1'b1;
          if (!full) begin
            w_state_nxt     = ST_WRITE;
            w_wr_en_nxt     = 1'b1;
            w_wr_data_nxt   = r_hold_data;
            w_err_full_nxt  = 1'b0;
            w_err_empty_nxt = 1'b0;
          end else begin
            w_state_nxt    = ST_HOLD;
            w_cnt_nxt      = CNT_LOAD;
            w_err_full_nxt = 1'b1;
          end
        end else if (r_pend_rd) begin
          w_rd_consume = 1'b1;
          if (!empty) begin
            w_state_nxt     = ST_READ;
            w_rd_en_nxt     = 1'b1;
            w_err_full_nxt  = 1'b0;
            w_err_empty_nxt = 1'b0;
          end else begin
            w_state_nxt     = ST_HOLD;
            w_cnt_nxt       = CNT_LOAD;
            w_err_empty_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE, ST_READ: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = CNT_LOAD;
      end
      ST_HOLD: begin
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= CNT_ZERO;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_data   <= {DATA_WIDTH{1'b0}};
      r_err_full  <= 1'b0;
      r_err_empty <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_err_full  <= w_err_full_nxt;
      r_err_empty <= w_err_empty_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign wr_en     = r_wr_en;
  assign rd_en     = r_rd_en;
  assign wr_data   = r_wr_data;
  assign err_full  = r_err_full;
  assign err_empty = r_err_empty;
  assign busy      = r_busy;

endmodule
